// File: rtl/pio_edge_irq_multi.sv
// pio_edge_irq_multi: Avalon-MM input PIO with synchroniser, runtime debounce and per-channel edge-capture interrupts
module pio_edge_irq_multi #(
   parameter int WIDTH = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W = 16,
   parameter logic [WIDTH-1:0] RISE_RST = '1,
   parameter logic [WIDTH-1:0] FALL_RST = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] s, f, f_next, hit;
   logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_cap, evt, clr;
   logic [CNT_W-1:0] db_limit, lim_m1;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [31:0] rd_mux;
   logic wr, unused_bits;

   assign wr = chipselect & ~write_n;
   assign s = sync_q[SYNC_STAGES-1];
   assign lim_m1 = db_limit - CNT_W'(1);
   assign evt = (f_next & ~f & rise_en) | (~f_next & f & fall_en);
   assign clr = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
   assign irq = |(edge_cap & irq_mask);
   assign unused_bits = ^writedata;

   // Shift the raw pins through the synchroniser chain
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};

   // A channel flips once the new level has held for DB_LIMIT cycles (immediately when DB_LIMIT is 0)
   always_comb begin
      hit = '0;
      f_next = f;
      for (int i = 0; i < WIDTH; i++) begin
         hit[i] = (s[i] != f[i]) && (db_limit == '0 || cnt[i] >= lim_m1);
         f_next[i] = hit[i] ? s[i] : f[i];
      end
   end

   // Debounce counters and filtered levels
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         f <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         f <= f_next;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= (s[i] == f[i] || hit[i]) ? '0 : cnt[i] + CNT_W'(1);
      end

   // Control registers written from the bus
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rise_en <= RISE_RST;
         fall_en <= FALL_RST;
         irq_mask <= '0;
         db_limit <= '0;
      end else if (wr) begin
         case (address)
            3'd1: rise_en <= writedata[WIDTH-1:0];
            3'd2: irq_mask <= writedata[WIDTH-1:0];
            3'd4: fall_en <= writedata[WIDTH-1:0];
            3'd5: db_limit <= writedata[CNT_W-1:0];
            default: ;
         endcase
      end

   // Edge capture: a new event on a bit wins over a simultaneous write-1-to-clear
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) edge_cap <= '0;
      else edge_cap <= (edge_cap & ~clr) | evt;

   // Read mux, zero-filling unused bits
   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0: rd_mux[WIDTH-1:0] = f;
         3'd1: rd_mux[WIDTH-1:0] = rise_en;
         3'd2: rd_mux[WIDTH-1:0] = irq_mask;
         3'd3: rd_mux[WIDTH-1:0] = edge_cap;
         3'd4: rd_mux[WIDTH-1:0] = fall_en;
         3'd5: rd_mux[CNT_W-1:0] = db_limit;
         default: ;
      endcase
   end

   // Read data is registered every cycle from the current address
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) readdata <= '0;
      else readdata <= rd_mux;

endmodule

// File: tb/tb_pio_edge_irq_multi.sv
// tb_pio_edge_irq_multi: directed self-checking bench for pio_edge_irq_multi
module tb_pio_edge_irq_multi;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [3:0]  in_port = '0;
   logic        irq;
   logic [31:0] rv;
   int checks = 0;
   int errors = 0;

   pio_edge_irq_multi dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .in_port(in_port),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a;
      chipselect = 1'b1;
      write_n = 1'b0;
      writedata = d;
      tick();
      chipselect = 1'b0;
      write_n = 1'b1;
      writedata = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   initial begin
      tick(3);
      reset_n = 1'b1;
      tick();
      // reset defaults
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), rv);
         chk($sformatf("reset_addr%0d", a), rv, (a == 1) ? 32'hF : 32'h0);
      end
      chk("reset_irq", {31'b0, irq}, 32'h0);
      // DB_LIMIT=0 rising edge latency of 3 cycles
      wr(3'd2, 32'h1);
      in_port[0] = 1'b1;
      tick();
      chk("lat0_c1", {31'b0, irq}, 32'h0);
      tick();
      chk("lat0_c2", {31'b0, irq}, 32'h0);
      tick();
      chk("lat0_c3", {31'b0, irq}, 32'h1);
      rd(3'd3, rv);
      chk("lat0_cap", rv, 32'h1);
      wr(3'd3, 32'h1);
      chk("w1c_irq", {31'b0, irq}, 32'h0);
      rd(3'd3, rv);
      chk("w1c_cap", rv, 32'h0);
      // falling-only capture on bit 1
      wr(3'd1, 32'h0);
      wr(3'd4, 32'h2);
      in_port[1] = 1'b1;
      tick(10);
      rd(3'd3, rv);
      chk("fall_rise_only", rv, 32'h0);
      rd(3'd0, rv);
      chk("fall_data_hi", rv, 32'h3);
      in_port[1] = 1'b0;
      tick(5);
      rd(3'd3, rv);
      chk("fall_cap", rv, 32'h2);
      rd(3'd0, rv);
      chk("fall_data_lo", rv, 32'h1);
      wr(3'd3, 32'hF);
      wr(3'd4, 32'h0);
      wr(3'd1, 32'hF);
      // debounce limit 5: 4-cycle glitch rejected, 5-cycle level accepted
      wr(3'd5, 32'h5);
      wr(3'd2, 32'h4);
      in_port[2] = 1'b1;
      tick(4);
      in_port[2] = 1'b0;
      tick(10);
      rd(3'd0, rv);
      chk("glitch_data", rv, 32'h1);
      rd(3'd3, rv);
      chk("glitch_cap", rv, 32'h0);
      chk("glitch_irq", {31'b0, irq}, 32'h0);
      in_port[2] = 1'b1;
      tick(6);
      chk("db5_c6", {31'b0, irq}, 32'h0);
      tick();
      chk("db5_c7", {31'b0, irq}, 32'h1);
      rd(3'd0, rv);
      chk("db5_data", rv, 32'h5);
      rd(3'd5, rv);
      chk("db5_limit", rv, 32'h5);
      wr(3'd3, 32'h4);
      chk("db5_clr_irq", {31'b0, irq}, 32'h0);
      // W1C colliding with a new rising event on bit 0
      wr(3'd5, 32'h0);
      in_port[3] = 1'b1;
      tick(5);
      in_port[0] = 1'b0;
      tick(5);
      rd(3'd3, rv);
      chk("coll_pre", rv, 32'h8);
      in_port[0] = 1'b1;
      tick(2);
      wr(3'd3, 32'h9);
      rd(3'd3, rv);
      chk("coll_cap", rv, 32'h1);
      // reset in the middle of a debounce count
      wr(3'd3, 32'hF);
      wr(3'd5, 32'd10);
      in_port[1] = 1'b1;
      tick(5);
      address = 3'd3;
      reset_n = 1'b0;
      #1;
      chk("rst_irq", {31'b0, irq}, 32'h0);
      tick();
      chk("rst_rdata", readdata, 32'h0);
      reset_n = 1'b1;
      tick();
      chk("rel_c1", readdata, 32'h0);
      tick();
      chk("rel_c2", readdata, 32'h0);
      tick();
      chk("rel_c3", readdata, 32'h0);
      tick();
      chk("rel_c4", readdata, 32'hF);
      rd(3'd5, rv);
      chk("rel_limit", rv, 32'h0);
      wr(3'd3, 32'hF);
      tick(5);
      rd(3'd3, rv);
      chk("rel_once", rv, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
